// File: rtl/idct_row_mul.sv
// Row-input multiplier stage of the 8-point IDCT: gathers 8 coefficients, then forms the 22 constant products used by idct_add0.
// Optional build macro IDCT_IN_CLAMP_EN saturates incoming coefficients to [-2048, 2047] before they are stored.
module idct_row_mul #(
    parameter int COEF_W = 16,
    parameter int FRAC   = 12,
    parameter int C1     = 4017,
    parameter int C2     = 3784,
    parameter int C3     = 3406,
    parameter int C4     = 2896,
    parameter int C5     = 2276,
    parameter int C6     = 1567,
    parameter int C7     = 799,
    parameter int C8     = 3406,
    parameter int C9     = 2276,
    parameter int C10    = 4017,
    parameter int C11    = 799
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [COEF_W-1:0] in_data,
    input  logic                     in_valid,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic signed [31:0]       in0_c4,
    output logic signed [31:0]       in1_c7,
    output logic signed [31:0]       in1_c1,
    output logic signed [31:0]       in2_c6,
    output logic signed [31:0]       in2_c2,
    output logic signed [31:0]       in3_c3,
    output logic signed [31:0]       in3_c5,
    output logic signed [31:0]       in4_c4,
    output logic signed [31:0]       in5_c3,
    output logic signed [31:0]       in5_c5,
    output logic signed [31:0]       in6_c6,
    output logic signed [31:0]       in6_c2,
    output logic signed [31:0]       in7_c7,
    output logic signed [31:0]       in7_c1,
    output logic signed [31:0]       in1_c8,
    output logic signed [31:0]       in1_c9,
    output logic signed [31:0]       in7_c8,
    output logic signed [31:0]       in7_c9,
    output logic signed [31:0]       in5_c10,
    output logic signed [31:0]       in5_c11,
    output logic signed [31:0]       in3_c10,
    output logic signed [31:0]       in3_c11,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     row_err
);

    localparam int P_W = COEF_W + FRAC + 1;

    typedef enum logic [1:0] {COLLECT, MULT, HOLD} state_t;

    state_t                    state, state_nxt;
    logic [2:0]                cnt;
    logic signed [COEF_W-1:0]  row_p0 [8];
    logic signed [COEF_W-1:0]  store_data;
    logic                      xfer;

    // Full-precision product; scaling is left to the adder stages.
    function automatic logic signed [31:0] mul_c(input logic signed [COEF_W-1:0] a, input int c);
        logic signed [FRAC:0]  k;
        logic signed [P_W-1:0] p;
        k = (FRAC+1)'(c);
        p = P_W'(a) * P_W'(k);
        return 32'(p);
    endfunction

`ifdef IDCT_IN_CLAMP_EN
    function automatic logic signed [COEF_W-1:0] sat_in(input logic signed [COEF_W-1:0] d);
        if (d > 2047)
            return COEF_W'(2047);
        else if (d < -2048)
            return COEF_W'(-2048);
        else
            return d;
    endfunction

    assign store_data = sat_in(in_data);
`else
    assign store_data = in_data;
`endif

    assign xfer = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            COLLECT: begin
                in_ready = 1'b1;
                if (xfer && cnt == 3'd7)
                    state_nxt = MULT;
            end
            MULT:    state_nxt = HOLD;
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = COLLECT;
            end
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= COLLECT;
            cnt     <= 3'd0;
            row_err <= 1'b0;
            for (int i = 0; i < 8; i++)
                row_p0[i] <= '0;
            in0_c4  <= '0; in1_c7  <= '0; in1_c1  <= '0; in2_c6  <= '0;
            in2_c2  <= '0; in3_c3  <= '0; in3_c5  <= '0; in4_c4  <= '0;
            in5_c3  <= '0; in5_c5  <= '0; in6_c6  <= '0; in6_c2  <= '0;
            in7_c7  <= '0; in7_c1  <= '0; in1_c8  <= '0; in1_c9  <= '0;
            in7_c8  <= '0; in7_c9  <= '0; in5_c10 <= '0; in5_c11 <= '0;
            in3_c10 <= '0; in3_c11 <= '0;
        end else begin
            state <= state_nxt;
            // Stage p0: beat capture; framing is judged by cnt alone.
            if (xfer) begin
                row_p0[cnt] <= store_data;
                cnt         <= cnt + 3'd1;
                if (in_last != (cnt == 3'd7))
                    row_err <= 1'b1;
            end
            // Stage p1: product registers, loaded in the single MULT cycle and held through HOLD.
            if (state == MULT) begin
                in0_c4  <= mul_c(row_p0[0], C4);
                in1_c7  <= mul_c(row_p0[1], C7);
                in1_c1  <= mul_c(row_p0[1], C1);
                in2_c6  <= mul_c(row_p0[2], C6);
                in2_c2  <= mul_c(row_p0[2], C2);
                in3_c3  <= mul_c(row_p0[3], C3);
                in3_c5  <= mul_c(row_p0[3], C5);
                in4_c4  <= mul_c(row_p0[4], C4);
                in5_c3  <= mul_c(row_p0[5], C3);
                in5_c5  <= mul_c(row_p0[5], C5);
                in6_c6  <= mul_c(row_p0[6], C6);
                in6_c2  <= mul_c(row_p0[6], C2);
                in7_c7  <= mul_c(row_p0[7], C7);
                in7_c1  <= mul_c(row_p0[7], C1);
                in1_c8  <= mul_c(row_p0[1], C8);
                in1_c9  <= mul_c(row_p0[1], C9);
                in7_c8  <= mul_c(row_p0[7], C8);
                in7_c9  <= mul_c(row_p0[7], C9);
                in5_c10 <= mul_c(row_p0[5], C10);
                in5_c11 <= mul_c(row_p0[5], C11);
                in3_c10 <= mul_c(row_p0[3], C10);
                in3_c11 <= mul_c(row_p0[3], C11);
            end
        end
    end

endmodule

// File: tb/tb_idct_row_mul.sv
// Scoreboard bench for idct_row_mul: expected product sets are queued as rows are sent and checked when out_valid appears.
module tb_idct_row_mul;
    localparam int COEF_W = 16;

    logic clk = 1'b0;
    logic rst, in_valid, in_last, out_ready;
    logic signed [COEF_W-1:0] in_data;
    logic in_ready, out_valid, row_err;
    logic signed [31:0] prod [22];

    typedef struct { int p[22]; } pset_t;
    pset_t sb_q[$];
    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    int prod_idx  [22] = '{0,1,1,2,2,3,3,4,5,5,6,6,7,7,1,1,7,7,5,5,3,3};
    int prod_coef [22] = '{2896,799,4017,1567,3784,3406,2276,2896,3406,2276,1567,3784,
                           799,4017,3406,2276,3406,2276,4017,799,4017,799};

    idct_row_mul dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready),
        .in0_c4(prod[0]), .in1_c7(prod[1]), .in1_c1(prod[2]), .in2_c6(prod[3]),
        .in2_c2(prod[4]), .in3_c3(prod[5]), .in3_c5(prod[6]), .in4_c4(prod[7]),
        .in5_c3(prod[8]), .in5_c5(prod[9]), .in6_c6(prod[10]), .in6_c2(prod[11]),
        .in7_c7(prod[12]), .in7_c1(prod[13]), .in1_c8(prod[14]), .in1_c9(prod[15]),
        .in7_c8(prod[16]), .in7_c9(prod[17]), .in5_c10(prod[18]), .in5_c11(prod[19]),
        .in3_c10(prod[20]), .in3_c11(prod[21]),
        .out_valid(out_valid), .out_ready(out_ready), .row_err(row_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int model_store(input int v);
`ifdef IDCT_IN_CLAMP_EN
        if (v > 2047) return 2047;
        if (v < -2048) return -2048;
`endif
        return v;
    endfunction

    function automatic pset_t model(input int row[8]);
        pset_t m;
        for (int k = 0; k < 22; k++)
            m.p[k] = model_store(row[prod_idx[k]]) * prod_coef[k];
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_row(input int row[8], input bit [7:0] lastm, input int nb);
        bit took;
        for (int i = 0; i < nb; i++) begin
            in_valid = 1'b1;
            in_data  = COEF_W'(row[i]);
            in_last  = lastm[i];
            took = 1'b0;
            for (int w = 0; w < 50 && !took; w++) begin
                took = in_ready;
                tick();
            end
            if (!took) begin
                n_cmp++; n_fail++;
                $display("FAIL send_row beat %0d: in_ready never 1 (got 0, required 1)", i);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Waits (bounded) for out_valid, captures the product set, then steps past the handshake edge.
    task automatic get_products(output pset_t got, output bit ok, output int at);
        ok = 1'b0;
        at = 0;
        for (int n = 0; n < 40 && !ok; n++) begin
            if (out_valid) begin
                for (int k = 0; k < 22; k++) got.p[k] = prod[k];
                at = cyc;
                ok = 1'b1;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid got %b required 0", out_valid); end
        n_cmp++; if (row_err !== 1'b0) begin n_fail++; $display("FAIL reset row_err got %b required 0", row_err); end
        for (int k = 0; k < 22; k++) begin
            n_cmp++;
            if (prod[k] !== 32'sd0) begin n_fail++; $display("FAIL reset prod[%0d] got %0d required 0", k, prod[k]); end
        end
        rst = 1'b0;
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready_after got %b required 1", in_ready); end
    endtask

    task automatic test_dc_latency();
        int row[8] = '{64,0,0,0,0,0,0,0};
        pset_t e;
        out_ready = 1'b1;
        sb_q.push_back(model(row));
        send_row(row, 8'h80, 8);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dc out_valid_mult got %b required 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL dc in_ready_mult got %b required 0", in_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL dc out_valid_latency got %b required 1", out_valid); end
        n_cmp++; if (prod[0] !== 32'sd185344) begin n_fail++; $display("FAIL dc in0_c4 got %0d required 185344", prod[0]); end
        e = sb_q.pop_front();
        for (int k = 0; k < 22; k++) begin
            n_cmp++;
            if (prod[k] !== e.p[k]) begin n_fail++; $display("FAIL dc prod[%0d] got %0d required %0d", k, prod[k], e.p[k]); end
        end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dc out_valid_after got %b required 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL dc in_ready_after got %b required 1", in_ready); end
        n_cmp++; if (row_err !== 1'b0) begin n_fail++; $display("FAIL dc row_err got %b required 0", row_err); end
    endtask

    task automatic test_unit_rows();
        int row[8];
        pset_t g, e;
        bit ok;
        int at;
        out_ready = 1'b1;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 8; i++) row[i] = (s == 0) ? 1 : -1;
            sb_q.push_back(model(row));
            send_row(row, 8'h80, 8);
            get_products(g, ok, at);
            n_cmp++; if (!ok) begin n_fail++; $display("FAIL unit out_valid timeout got 0 required 1"); end
            e = sb_q.pop_front();
            for (int k = 0; k < 22; k++) begin
                n_cmp++;
                if (g.p[k] !== e.p[k]) begin n_fail++; $display("FAIL unit%0d prod[%0d] got %0d required %0d", s, k, g.p[k], e.p[k]); end
            end
            if (s == 0) begin
                n_cmp++; if (g.p[2]  !== 4017) begin n_fail++; $display("FAIL ones in1_c1 got %0d required 4017", g.p[2]); end
                n_cmp++; if (g.p[3]  !== 1567) begin n_fail++; $display("FAIL ones in2_c6 got %0d required 1567", g.p[3]); end
                n_cmp++; if (g.p[17] !== 2276) begin n_fail++; $display("FAIL ones in7_c9 got %0d required 2276", g.p[17]); end
                n_cmp++; if (g.p[18] !== 4017) begin n_fail++; $display("FAIL ones in5_c10 got %0d required 4017", g.p[18]); end
                n_cmp++; if (g.p[21] !== 799)  begin n_fail++; $display("FAIL ones in3_c11 got %0d required 799", g.p[21]); end
            end else begin
                n_cmp++; if (g.p[3] !== -1567) begin n_fail++; $display("FAIL neg in2_c6 got %h required fffff9e1", g.p[3]); end
                n_cmp++; if (g.p[7] !== -2896) begin n_fail++; $display("FAIL neg in4_c4 got %0d required -2896", g.p[7]); end
            end
        end
    endtask

    task automatic test_hold();
        int row[8];
        pset_t e, g;
        bit ok, stable;
        int at;
        for (int i = 0; i < 8; i++) row[i] = int'($urandom_range(4095)) - 2048;
        out_ready = 1'b0;
        sb_q.push_back(model(row));
        send_row(row, 8'h80, 8);
        ok = 1'b0;
        for (int n = 0; n < 10 && !ok; n++) begin
            if (out_valid) ok = 1'b1; else tick();
        end
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL hold out_valid timeout got 0 required 1"); end
        e = sb_q.pop_front();
        in_valid = 1'b1; in_data = 16'sd123; in_last = 1'b1;
        for (int c = 0; c < 5; c++) begin
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hold out_valid cyc%0d got %b required 1", c, out_valid); end
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold in_ready cyc%0d got %b required 0", c, in_ready); end
            stable = 1'b1;
            for (int k = 0; k < 22; k++) if (prod[k] !== e.p[k]) stable = 1'b0;
            n_cmp++; if (!stable) begin n_fail++; $display("FAIL hold products cyc%0d got in0_c4=%0d required %0d", c, prod[0], e.p[0]); end
            tick();
        end
        in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b1;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold release out_valid got %b required 0", out_valid); end
        for (int i = 0; i < 8; i++) row[i] = 10 * i - 35;
        sb_q.push_back(model(row));
        send_row(row, 8'h80, 8);
        get_products(g, ok, at);
        e = sb_q.pop_front();
        for (int k = 0; k < 22; k++) begin
            n_cmp++;
            if (!ok || g.p[k] !== e.p[k]) begin n_fail++; $display("FAIL hold next prod[%0d] got %0d required %0d", k, g.p[k], e.p[k]); end
        end
        n_cmp++; if (row_err !== 1'b0) begin n_fail++; $display("FAIL hold row_err got %b required 0", row_err); end
    endtask

    task automatic test_clamp();
        int row[8] = '{3000,-3000,2047,-2048,0,0,0,5};
        int want;
        pset_t g, e;
        bit ok;
        int at;
`ifdef IDCT_IN_CLAMP_EN
        want = 5928112;
`else
        want = 8688000;
`endif
        out_ready = 1'b1;
        sb_q.push_back(model(row));
        send_row(row, 8'h80, 8);
        get_products(g, ok, at);
        e = sb_q.pop_front();
        n_cmp++; if (!ok || g.p[0] !== want) begin n_fail++; $display("FAIL clamp in0_c4 got %0d required %0d", g.p[0], want); end
        for (int k = 0; k < 22; k++) begin
            n_cmp++;
            if (g.p[k] !== e.p[k]) begin n_fail++; $display("FAIL clamp prod[%0d] got %0d required %0d", k, g.p[k], e.p[k]); end
        end
        n_cmp++; if (row_err !== 1'b0) begin n_fail++; $display("FAIL clamp row_err got %b required 0", row_err); end
    endtask

    task automatic test_framing();
        int row[8] = '{-7,300,-1000,17,1,-2,900,-2048};
        pset_t g, e;
        bit ok;
        int at;
        out_ready = 1'b1;
        send_row(row, 8'h08, 5);
        n_cmp++; if (row_err !== 1'b1) begin n_fail++; $display("FAIL frame early_last row_err got %b required 1", row_err); end
        in_valid = 1'b1; in_data = 16'sd55; rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        n_cmp++; if (row_err !== 1'b0) begin n_fail++; $display("FAIL frame rst row_err got %b required 0", row_err); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL frame rst out_valid got %b required 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL frame rst in_ready got %b required 1", in_ready); end
        for (int pass = 0; pass < 2; pass++) begin
            sb_q.push_back(model(row));
            send_row(row, (pass == 0) ? 8'h80 : 8'h00, 8);
            get_products(g, ok, at);
            e = sb_q.pop_front();
            for (int k = 0; k < 22; k++) begin
                n_cmp++;
                if (!ok || g.p[k] !== e.p[k]) begin n_fail++; $display("FAIL frame%0d prod[%0d] got %0d required %0d", pass, k, g.p[k], e.p[k]); end
            end
            n_cmp++;
            if (row_err !== (pass == 1)) begin n_fail++; $display("FAIL frame%0d row_err got %b required %0d", pass, row_err, pass); end
        end
        out_ready = 1'b0;
        send_row(row, 8'h80, 8);
        tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL frame hold out_valid got %b required 1", out_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL frame hold_rst out_valid got %b required 0", out_valid); end
        n_cmp++; if (prod[0] !== 32'sd0) begin n_fail++; $display("FAIL frame hold_rst in0_c4 got %0d required 0", prod[0]); end
        n_cmp++; if (row_err !== 1'b0) begin n_fail++; $display("FAIL frame hold_rst row_err got %b required 0", row_err); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        fork
            begin
                int row[8];
                for (int r = 0; r < 6; r++) begin
                    for (int i = 0; i < 8; i++) row[i] = int'($urandom_range(4095)) - 2048;
                    sb_q.push_back(model(row));
                    send_row(row, 8'h80, 8);
                end
            end
            begin
                pset_t g, e;
                bit ok;
                int at, prev_at;
                prev_at = 0;
                for (int r = 0; r < 6; r++) begin
                    get_products(g, ok, at);
                    n_cmp++; if (!ok) begin n_fail++; $display("FAIL b2b row%0d out_valid timeout got 0 required 1", r); end
                    if (ok && sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        for (int k = 0; k < 22; k++) begin
                            n_cmp++;
                            if (g.p[k] !== e.p[k]) begin n_fail++; $display("FAIL b2b row%0d prod[%0d] got %0d required %0d", r, k, g.p[k], e.p[k]); end
                        end
                    end
                    if (r > 0) begin
                        n_cmp++;
                        if (at - prev_at !== 10) begin n_fail++; $display("FAIL b2b row%0d period got %0d required 10", r, at - prev_at); end
                    end
                    prev_at = at;
                end
            end
        join
        n_cmp++; if (row_err !== 1'b0) begin n_fail++; $display("FAIL b2b row_err got %b required 0", row_err); end
        n_cmp++; if (sb_q.size() !== 0) begin n_fail++; $display("FAIL b2b queue_left got %0d required 0", sb_q.size()); end
    endtask

    initial begin
        test_reset();
        test_dc_latency();
        test_unit_rows();
        test_hold();
        test_clamp();
        test_framing();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
